// File: rtl/tdt_dtm_io_ctrl_if.sv
// Purpose : bundles the pad-side and controller/chain-side signals of the DTM pad interface.
// Latency : none; plain wires.
// Backpressure: none; the turnaround handshake is carried by tms_busy/tms_valid.
// Ports   : slave  = the pad interface block (pad/ctrl/chain inputs in, pad/ctrl/chain outputs out)
//           master = whatever drives the pads and the controller side (pads, ctrl, chains).
interface tdt_dtm_io_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
);
  // pad side
  logic              pad_dtm_jtag2_sel;
  logic              pad_dtm_tap_en;
  logic              pad_dtm_tdi;
  logic              pad_dtm_tms_i;
  logic              dtm_pad_tdo;
  logic              dtm_pad_tdo_en;
  logic              dtm_pad_tms_o;
  logic              dtm_pad_tms_oe;
  // chain / controller side
  logic [NUM_CH-1:0] chain_io_tdo;
  logic [CH_W-1:0]   ctrl_io_chain_sel;
  logic              ctrl_io_tdo_en;
  logic              ctrl_io_tms_oe;
  logic              io_chain_tdi;
  logic              io_ctrl_tap_en;
  logic              io_ctrl_tms_busy;
  logic              io_ctrl_tms_valid;

  modport slave (
    input  pad_dtm_jtag2_sel, pad_dtm_tap_en, pad_dtm_tdi, pad_dtm_tms_i,
    input  chain_io_tdo, ctrl_io_chain_sel, ctrl_io_tdo_en, ctrl_io_tms_oe,
    output dtm_pad_tdo, dtm_pad_tdo_en, dtm_pad_tms_o, dtm_pad_tms_oe,
    output io_chain_tdi, io_ctrl_tap_en, io_ctrl_tms_busy, io_ctrl_tms_valid
  );

  modport master (
    output pad_dtm_jtag2_sel, pad_dtm_tap_en, pad_dtm_tdi, pad_dtm_tms_i,
    output chain_io_tdo, ctrl_io_chain_sel, ctrl_io_tdo_en, ctrl_io_tms_oe,
    input  dtm_pad_tdo, dtm_pad_tdo_en, dtm_pad_tms_o, dtm_pad_tms_oe,
    input  io_chain_tdi, io_ctrl_tap_en, io_ctrl_tms_busy, io_ctrl_tms_valid
  );
endinterface

// File: rtl/tdt_dtm_io_ctrl.sv
// Purpose : DTM pad interface: TDO chain mux, registered TDO, 2-wire TMS pin-direction FSM.
// Latency : TDO / TDO enable / TMS out 1 tclk; tap_en and chain TDI are combinational.
// Backpressure: none; chains must only consume TDI while tms_valid=1 in 2-wire mode.
// Ports   : pad_dtm_tclk (clock), pad_dtm_trst_b (async active-low reset),
//           io (slave modport): pad TDI/TMS/TDO/mode pins, chain TDO/TDI, controller requests/status.
module tdt_dtm_io_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TURN_CYC = 1
) (
  input  logic               pad_dtm_tclk,
  input  logic               pad_dtm_trst_b,
  tdt_dtm_io_ctrl_if.slave   io
);

  typedef enum logic [1:0] {
    S_IN       = 2'd0,
    S_TURN_OUT = 2'd1,
    S_OUT      = 2'd2,
    S_TURN_IN  = 2'd3
  } state_t;

  // Counter reload: TURN_CYC-1, kept at 0 when turnarounds are disabled.
  localparam logic [2:0] CNT_LOAD = (TURN_CYC == 0) ? 3'd0 : 3'(TURN_CYC - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       sel_tdo;
  logic       two_wire;
  logic       req;

  assign io.io_ctrl_tap_en = io.pad_dtm_tap_en;
  assign io.io_chain_tdi   = io.pad_dtm_jtag2_sel ? io.pad_dtm_tms_i : io.pad_dtm_tdi;

  assign two_wire = io.pad_dtm_jtag2_sel & io.pad_dtm_tap_en;
  assign req      = io.ctrl_io_tms_oe;

  // Out-of-range chain index reads as idle-high TDO.
  always_comb begin
    sel_tdo = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (io.ctrl_io_chain_sel == CH_W'(i)) sel_tdo = io.chain_io_tdo[i];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!two_wire) begin
      // Leaving 2-wire mode or disabling the TAP abandons any turnaround.
      state_nxt = S_IN;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        S_IN: begin
          if (req) begin
            state_nxt = (TURN_CYC == 0) ? S_OUT : S_TURN_OUT;
            cnt_nxt   = CNT_LOAD;
          end
        end
        S_TURN_OUT: begin
          if (!req)              state_nxt = S_IN;
          else if (cnt == 3'd0)  state_nxt = S_OUT;
          else                   cnt_nxt   = cnt - 3'd1;
        end
        S_OUT: begin
          if (!req) begin
            state_nxt = (TURN_CYC == 0) ? S_IN : S_TURN_IN;
            cnt_nxt   = CNT_LOAD;
          end
        end
        S_TURN_IN: begin
          // The host may already be driving; never cut this turnaround short.
          if (cnt == 3'd0) begin
            if (req) begin
              state_nxt = S_TURN_OUT;
              cnt_nxt   = CNT_LOAD;
            end else begin
              state_nxt = S_IN;
            end
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: begin
          state_nxt = S_IN;
          cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // State, counter and all pad/status outputs are flops; status flags are the
  // decode of the next state so they line up exactly with the registered state.
  always_ff @(posedge pad_dtm_tclk or negedge pad_dtm_trst_b) begin
    if (!pad_dtm_trst_b) begin
      state                <= S_IN;
      cnt                  <= 3'd0;
      io.dtm_pad_tdo       <= 1'b0;
      io.dtm_pad_tdo_en    <= 1'b0;
      io.dtm_pad_tms_o     <= 1'b0;
      io.dtm_pad_tms_oe    <= 1'b0;
      io.io_ctrl_tms_busy  <= 1'b0;
      io.io_ctrl_tms_valid <= 1'b1;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      io.dtm_pad_tdo       <= sel_tdo;
      io.dtm_pad_tdo_en    <= io.ctrl_io_tdo_en & io.pad_dtm_tap_en & ~io.pad_dtm_jtag2_sel;
      // TMS data only tracks the chain while the pin is ours; otherwise it holds.
      if (state == S_OUT) io.dtm_pad_tms_o <= sel_tdo;
      io.dtm_pad_tms_oe    <= (state_nxt == S_OUT);
      io.io_ctrl_tms_busy  <= (state_nxt == S_TURN_OUT) || (state_nxt == S_TURN_IN);
      io.io_ctrl_tms_valid <= (state_nxt == S_IN);
    end
  end

endmodule

// File: tb/tb_tdt_dtm_io_ctrl.sv
// Purpose : directed bench for tdt_dtm_io_ctrl; two builds (3 chains/2 turn cycles, 2 chains/0 turn cycles).
// Latency : expectations describe outputs one tclk after the vector is applied (async reset: immediately).
// Backpressure: none; stimulus pushes expectations, a monitor pops and compares.
module tb_tdt_dtm_io_ctrl;

  logic tclk;
  logic rst_n;

  tdt_dtm_io_ctrl_if #(.NUM_CH(3), .CH_W(2)) ifa ();
  tdt_dtm_io_ctrl_if #(.NUM_CH(2), .CH_W(1)) ifb ();

  tdt_dtm_io_ctrl #(.NUM_CH(3), .CH_W(2), .TURN_CYC(2)) dut_a (
    .pad_dtm_tclk   (tclk),
    .pad_dtm_trst_b (rst_n),
    .io             (ifa)
  );

  tdt_dtm_io_ctrl #(.NUM_CH(2), .CH_W(1), .TURN_CYC(0)) dut_b (
    .pad_dtm_tclk   (tclk),
    .pad_dtm_trst_b (rst_n),
    .io             (ifb)
  );

  // expected bits: {tdo, tdo_en, tms_o, tms_oe, busy, valid, tap_en, chain_tdi}
  typedef struct {
    bit         dut;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  string fld [8] = '{"chain_tdi", "tap_en", "valid", "busy", "tms_oe", "tms_o", "tdo_en", "tdo"};

  initial begin
    tclk = 1'b0;
    forever #5 tclk = ~tclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] actual(input bit d);
    if (d)
      return {ifb.dtm_pad_tdo, ifb.dtm_pad_tdo_en, ifb.dtm_pad_tms_o, ifb.dtm_pad_tms_oe,
              ifb.io_ctrl_tms_busy, ifb.io_ctrl_tms_valid, ifb.io_ctrl_tap_en, ifb.io_chain_tdi};
    return {ifa.dtm_pad_tdo, ifa.dtm_pad_tdo_en, ifa.dtm_pad_tms_o, ifa.dtm_pad_tms_oe,
            ifa.io_ctrl_tms_busy, ifa.io_ctrl_tms_valid, ifa.io_ctrl_tap_en, ifa.io_chain_tdi};
  endfunction

  // Monitor: outputs settle after a clock edge or an asynchronous reset assertion.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge tclk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = actual(e.dut);
        for (int i = 7; i >= 0; i--) begin
          total++;
          if (act[i] !== e.exp[i]) begin
            bad++;
            $display("FAIL %s.%s got=%0b want=%0b", e.name, fld[i], act[i], e.exp[i]);
          end
        end
      end
    end
  end

  task automatic step(input bit d, input string nm, input bit rst, input bit j2, input bit tap,
                      input bit tdi, input bit tmsi, input logic [2:0] ch, input logic [1:0] sel,
                      input bit ten, input bit req, input logic [7:0] e);
    exp_t item;
    @(negedge tclk);
    if (d) begin
      ifb.pad_dtm_jtag2_sel = j2;
      ifb.pad_dtm_tap_en    = tap;
      ifb.pad_dtm_tdi       = tdi;
      ifb.pad_dtm_tms_i     = tmsi;
      ifb.chain_io_tdo      = ch[1:0];
      ifb.ctrl_io_chain_sel = sel[0];
      ifb.ctrl_io_tdo_en    = ten;
      ifb.ctrl_io_tms_oe    = req;
    end else begin
      ifa.pad_dtm_jtag2_sel = j2;
      ifa.pad_dtm_tap_en    = tap;
      ifa.pad_dtm_tdi       = tdi;
      ifa.pad_dtm_tms_i     = tmsi;
      ifa.chain_io_tdo      = ch;
      ifa.ctrl_io_chain_sel = sel;
      ifa.ctrl_io_tdo_en    = ten;
      ifa.ctrl_io_tms_oe    = req;
    end
    rst_n     = rst;
    item.dut  = d;
    item.exp  = e;
    item.name = nm;
    sb.push_back(item);
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.pad_dtm_jtag2_sel = 1'b0; ifa.pad_dtm_tap_en = 1'b0; ifa.pad_dtm_tdi = 1'b0;
    ifa.pad_dtm_tms_i = 1'b0; ifa.chain_io_tdo = '0; ifa.ctrl_io_chain_sel = '0;
    ifa.ctrl_io_tdo_en = 1'b0; ifa.ctrl_io_tms_oe = 1'b0;
    ifb.pad_dtm_jtag2_sel = 1'b0; ifb.pad_dtm_tap_en = 1'b0; ifb.pad_dtm_tdi = 1'b0;
    ifb.pad_dtm_tms_i = 1'b0; ifb.chain_io_tdo = '0; ifb.ctrl_io_chain_sel = '0;
    ifb.ctrl_io_tdo_en = 1'b0; ifb.ctrl_io_tms_oe = 1'b0;

    //   dut name        rst j2 tap tdi tms chain   sel   ten req  expected
    // 4-wire TDO path on the 3-chain build
    step(0, "a_reset",    0, 0, 0, 0, 0, 3'b000, 2'd0, 0, 0, 8'b0000_0100);
    step(0, "a_sel1",     1, 0, 1, 1, 0, 3'b010, 2'd1, 1, 0, 8'b1100_0111);
    step(0, "a_sel0",     1, 0, 1, 0, 1, 3'b010, 2'd0, 1, 0, 8'b0100_0110);
    step(0, "a_sel_oor",  1, 0, 1, 1, 0, 3'b000, 2'd3, 0, 0, 8'b1000_0111);
    step(0, "a_sel2_tap0",1, 0, 0, 0, 0, 3'b100, 2'd2, 1, 0, 8'b1000_0100);
    step(0, "a_2w_idle",  1, 1, 1, 0, 1, 3'b000, 2'd0, 1, 0, 8'b0000_0111);
    // 2-wire, two turnaround cycles out and in
    step(0, "a_to1",      1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1000_1010);
    step(0, "a_to2",      1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1000_1010);
    step(0, "a_out1",     1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1001_0010);
    step(0, "a_out2",     1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1011_0010);
    step(0, "a_out3",     1, 1, 1, 0, 0, 3'b000, 2'd0, 0, 1, 8'b0001_0010);
    step(0, "a_ti1",      1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 0, 8'b1010_1010);
    step(0, "a_ti2",      1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 0, 8'b1010_1010);
    step(0, "a_in",       1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 0, 8'b1010_0110);
    // request drops during turn-out
    step(0, "a_abort_to", 1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "a_abort_in", 1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 0, 8'b1010_0110);
    // request rises again during turn-in
    step(0, "b2b_to1",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "b2b_to2",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "b2b_out",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1011_0010);
    step(0, "b2b_ti1",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 0, 8'b1010_1010);
    step(0, "b2b_ti2",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "b2b_to3",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "b2b_to4",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "b2b_out2",   1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1011_0010);
    // override from OUT: leave 2-wire mode, then TAP disable
    step(0, "ovr_j2",     1, 0, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_0110);
    step(0, "ovr2_to1",   1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "ovr2_to2",   1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "ovr2_out",   1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1011_0010);
    step(0, "ovr_tap",    1, 1, 0, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_0100);
    // asynchronous reset while driving TMS
    step(0, "rst_to1",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "rst_to2",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1010_1010);
    step(0, "rst_out",    1, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b1011_0010);
    step(0, "rst_async",  0, 1, 1, 0, 0, 3'b001, 2'd0, 0, 1, 8'b0000_0110);
    // 2-chain build without turnaround cycles
    step(1, "b_sel1",     1, 0, 1, 1, 0, 3'b010, 2'd1, 1, 0, 8'b1100_0111);
    step(1, "b_sel0",     1, 0, 1, 0, 0, 3'b010, 2'd0, 1, 0, 8'b0100_0110);
    step(1, "b_out1",     1, 1, 1, 0, 1, 3'b001, 2'd0, 1, 1, 8'b1001_0011);
    step(1, "b_out2",     1, 1, 1, 0, 1, 3'b001, 2'd0, 1, 1, 8'b1011_0011);
    step(1, "b_in",       1, 1, 1, 0, 1, 3'b001, 2'd0, 1, 0, 8'b1010_0111);
    step(1, "b_out3",     1, 1, 1, 0, 1, 3'b000, 2'd0, 1, 1, 8'b0011_0011);
    step(1, "b_in2",      1, 1, 1, 0, 1, 3'b000, 2'd0, 1, 0, 8'b0000_0111);

    @(negedge tclk);
    @(negedge tclk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending expectations", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
